// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: widths, limits and small
// helpers used by the arbiter and its round-robin picker.
`ifndef DATA_ROW_WIDTH
`define DATA_ROW_WIDTH 32
`endif
`ifndef DATA_ADDRESS_WIDTH
`define DATA_ADDRESS_WIDTH 8
`endif

package ram_port_arbiter_pkg;

  // Largest supported requester count; the tag width is sized for NUM_REQ.
  localparam int RAM_ARB_MAX_REQ    = 8;
  localparam int DATA_ROW_WIDTH     = `DATA_ROW_WIDTH;
  localparam int DATA_ADDRESS_WIDTH = `DATA_ADDRESS_WIDTH;

  // Width of a requester index (at least one bit).
  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Position of requester idx in the rotated priority order starting at ptr.
  function automatic int rot_dist(input int idx, input int ptr, input int n);
    return (idx >= ptr) ? (idx - ptr) : (idx + n - ptr);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signal bundle of the RAM port arbiter.
//
// Handshake: requester i presents an operation by raising iReqValid[i] with
// iReqWrite/iReqAddr/iReqData; the operation is accepted on the rising Clock
// edge where iReqValid[i] & oReqGrant[i] are both 1. oReqGrant is
// combinational and may depend on iReqValid, so the requester must hold all
// its fields stable until accepted. Read data comes back on oRspValid[i] /
// oRspData slice i exactly one cycle after acceptance; writes return nothing.
interface ram_port_arbiter_if
  import ram_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_ROW_WIDTH,
  parameter int ADDR_WIDTH = DATA_ADDRESS_WIDTH,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            iReqValid;
  logic [NUM_REQ-1:0]            iReqWrite;
  logic [NUM_REQ*ADDR_WIDTH-1:0] iReqAddr;
  logic [NUM_REQ*DATA_WIDTH-1:0] iReqData;
  logic [NUM_REQ-1:0]            oReqGrant;
  logic [NUM_REQ-1:0]            oRspValid;
  logic [NUM_REQ*DATA_WIDTH-1:0] oRspData;
  logic                          oRamWriteEnable;
  logic [ADDR_WIDTH-1:0]         oRamWriteAddr;
  logic [DATA_WIDTH-1:0]         oRamWriteData;
  logic [ADDR_WIDTH-1:0]         oRamReadAddr0;
  logic [ADDR_WIDTH-1:0]         oRamReadAddr1;
  logic [DATA_WIDTH-1:0]         iRamData0;
  logic [DATA_WIDTH-1:0]         iRamData1;

  // Requesters plus the RAM model drive this side.
  modport master (
    output iReqValid, iReqWrite, iReqAddr, iReqData, iRamData0, iRamData1,
    input  oReqGrant, oRspValid, oRspData, oRamWriteEnable, oRamWriteAddr,
           oRamWriteData, oRamReadAddr0, oRamReadAddr1
  );

  // The arbiter sits on this side.
  modport slave (
    input  iReqValid, iReqWrite, iReqAddr, iReqData, iRamData0, iRamData1,
    output oReqGrant, oRspValid, oRspData, oRamWriteEnable, oRamWriteAddr,
           oRamWriteData, oRamReadAddr0, oRamReadAddr1
  );
endinterface

// File: rtl/ram_port_arbiter_rr_select.sv
// Rotated-priority picker: finds the first and second set bits of a request
// mask, searching from ptr upward and wrapping modulo N.
module ram_port_arbiter_rr_select #(
  parameter int N     = 4,
  parameter int TAG_W = 2
) (
  input  logic [N-1:0]     mask,
  input  logic [TAG_W-1:0] ptr,
  output logic [N-1:0]     first_onehot,
  output logic [TAG_W-1:0] first_idx,
  output logic             first_found,
  output logic [N-1:0]     second_onehot,
  output logic [TAG_W-1:0] second_idx,
  output logic             second_found
);

  logic [N-1:0]   rot;
  logic [TAG_W:0] pos;

  // Rotate the mask so bit 0 is the pointer position, then scan upward.
  always_comb begin
    rot           = N'({mask, mask} >> ptr);
    pos           = '0;
    first_onehot  = '0;
    first_idx     = '0;
    first_found   = 1'b0;
    second_onehot = '0;
    second_idx    = '0;
    second_found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (TAG_W+1)'(k);
      if (pos >= (TAG_W+1)'(N)) begin
        pos = pos - (TAG_W+1)'(N);
      end
      if (rot[k]) begin
        if (!first_found) begin
          first_found  = 1'b1;
          first_idx    = pos[TAG_W-1:0];
          first_onehot = N'(1) << pos[TAG_W-1:0];
        end else if (!second_found) begin
          second_found  = 1'b1;
          second_idx    = pos[TAG_W-1:0];
          second_onehot = N'(1) << pos[TAG_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM with 1 write port and 2 read ports among NUM_REQ requesters.
// Each cycle grants up to one write and two reads in round-robin order; a read
// hitting the address being written this cycle is deferred so it observes the
// new data. Read data is routed back, tagged, one cycle after the grant.
// NUM_REQ is expected in 2..RAM_ARB_MAX_REQ.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_ROW_WIDTH,
  parameter int ADDR_WIDTH = DATA_ADDRESS_WIDTH,
  parameter int NUM_REQ    = 4
) (
  input  logic               Clock,
  input  logic               Reset_n,
  ram_port_arbiter_if.slave  bus
);

  localparam int TAG_W = tag_w(NUM_REQ);

  logic [TAG_W-1:0]   ptr;
  logic [TAG_W-1:0]   ptr_next;
  logic [TAG_W-1:0]   first_granted;

  logic [NUM_REQ-1:0] wr_mask;
  logic [NUM_REQ-1:0] rd_mask;
  logic [NUM_REQ-1:0] wr_onehot;
  logic [TAG_W-1:0]   wr_idx;
  logic               wr_found;
  logic [NUM_REQ-1:0] rd0_onehot;
  logic [TAG_W-1:0]   rd0_idx;
  logic               rd0_found;
  logic [NUM_REQ-1:0] rd1_onehot;
  logic [TAG_W-1:0]   rd1_idx;
  logic               rd1_found;
  logic [NUM_REQ-1:0] grant;

  logic [NUM_REQ-1:0] unused_wr_second_onehot;
  logic [TAG_W-1:0]   unused_wr_second_idx;
  logic               unused_wr_second_found;

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] rd0_addr;
  logic [ADDR_WIDTH-1:0] rd1_addr;

  logic                  rd_tag0_valid;
  logic [TAG_W-1:0]      rd_tag0_idx;
  logic                  rd_tag1_valid;
  logic [TAG_W-1:0]      rd_tag1_idx;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data_q;
  logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data;

  // Writers compete for the single write slot.
  assign wr_mask = bus.iReqValid & bus.iReqWrite;

  ram_port_arbiter_rr_select #(.N(NUM_REQ), .TAG_W(TAG_W)) u_wr_select (
    .mask          (wr_mask),
    .ptr           (ptr),
    .first_onehot  (wr_onehot),
    .first_idx     (wr_idx),
    .first_found   (wr_found),
    .second_onehot (unused_wr_second_onehot),
    .second_idx    (unused_wr_second_idx),
    .second_found  (unused_wr_second_found)
  );

  // Select the winning write and build the reader mask, dropping reads that
  // target the address being written this cycle.
  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    rd_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_onehot[i]) begin
        wr_addr = bus.iReqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wr_data = bus.iReqData[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_mask[i] = bus.iReqValid[i] & ~bus.iReqWrite[i] &
                   ~(wr_found && (bus.iReqAddr[i*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr));
    end
  end

  ram_port_arbiter_rr_select #(.N(NUM_REQ), .TAG_W(TAG_W)) u_rd_select (
    .mask          (rd_mask),
    .ptr           (ptr),
    .first_onehot  (rd0_onehot),
    .first_idx     (rd0_idx),
    .first_found   (rd0_found),
    .second_onehot (rd1_onehot),
    .second_idx    (rd1_idx),
    .second_found  (rd1_found)
  );

  // Route the two granted readers' addresses to the RAM read ports.
  always_comb begin
    rd0_addr = '0;
    rd1_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd0_onehot[i]) rd0_addr = bus.iReqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (rd1_onehot[i]) rd1_addr = bus.iReqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Next pointer: one past the earliest granted requester in priority order.
  // The second reader always follows the first, so only the writer and the
  // first reader can be earliest.
  always_comb begin
    if (wr_found && (!rd0_found ||
        rot_dist(int'(wr_idx), int'(ptr), NUM_REQ) < rot_dist(int'(rd0_idx), int'(ptr), NUM_REQ))) begin
      first_granted = wr_idx;
    end else begin
      first_granted = rd0_idx;
    end
    ptr_next = (first_granted == TAG_W'(NUM_REQ-1)) ? '0 : first_granted + TAG_W'(1);
  end

  assign grant = wr_onehot | rd0_onehot | rd1_onehot;

  assign bus.oReqGrant       = grant;
  assign bus.oRamWriteEnable = wr_found;
  assign bus.oRamWriteAddr   = wr_addr;
  assign bus.oRamWriteData   = wr_data;
  assign bus.oRamReadAddr0   = rd0_addr;
  assign bus.oRamReadAddr1   = rd1_addr;

  // Steer RAM data to the tagged requesters; all other slices keep their value.
  always_comb begin
    rsp_data = rsp_data_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd_tag0_valid && rd_tag0_idx == TAG_W'(i)) begin
        rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = bus.iRamData0;
      end else if (rd_tag1_valid && rd_tag1_idx == TAG_W'(i)) begin
        rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = bus.iRamData1;
      end
    end
  end

  assign bus.oRspValid = rsp_valid_q;
  assign bus.oRspData  = rsp_data;

  // Round-robin pointer, in-flight read tags and held response data.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr           <= '0;
      rd_tag0_valid <= 1'b0;
      rd_tag0_idx   <= '0;
      rd_tag1_valid <= 1'b0;
      rd_tag1_idx   <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
    end else begin
      if (|grant) begin
        ptr <= ptr_next;
      end
      rd_tag0_valid <= rd0_found;
      rd_tag0_idx   <= rd0_idx;
      rd_tag1_valid <= rd1_found;
      rd_tag1_idx   <= rd1_idx;
      rsp_valid_q   <= rd0_onehot | rd1_onehot;
      rsp_data_q    <= rsp_data;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios followed by random traffic,
// checked against a cycle-level reference model and a response scoreboard.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int DW    = DATA_ROW_WIDTH;
  localparam int AW    = DATA_ADDRESS_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam int EW    = 32 + 8 + DW;   // {grant cycle, requester, data}

  // ---------------- clock / reset ----------------
  logic Clock   = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) bus ();

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // RAM behind the arbiter: 1-cycle read latency, read-before-write.
  // Nothing is written while reset is asserted.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge Clock) begin
    if (Reset_n && bus.oRamWriteEnable) ram[bus.oRamWriteAddr] <= bus.oRamWriteData;
    bus.iRamData0 <= ram[bus.oRamReadAddr0];
    bus.iRamData1 <= ram[bus.oRamReadAddr1];
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // ---------------- reference model state ----------------
  logic [DW-1:0] m_mem [DEPTH];
  int            m_ptr = 0;
  int            mode  = 1;
  int            last_nrd = 0;
  logic [N-1:0]  last_grant;
  int            wait_cnt [N];
  int            max_wait = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] req_addr(input int i);
    return bus.iReqAddr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] req_data(input int i);
    return bus.iReqData[i*DW +: DW];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.iReqValid[i]         = v;
    bus.iReqWrite[i]         = w;
    bus.iReqAddr[i*AW +: AW] = a;
    bus.iReqData[i*DW +: DW] = d;
  endtask

  // Next operation for requester i: 0 random, 1 fixed reader at 10+i,
  // 2 saturating with private addresses, 3 idle.
  task automatic new_op(input int i, input int m);
    case (m)
      0: set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 AW'($urandom_range(0, 7)), DW'($urandom));
      1: set_req(i, 1'b1, 1'b0, AW'(10 + i), '0);
      2: set_req(i, 1'b1, $urandom_range(0, 1) == 1,
                 AW'(i * 16 + $urandom_range(0, 3)), DW'($urandom));
      default: set_req(i, 1'b0, 1'b0, '0, '0);
    endcase
  endtask

  // One arbitration cycle. Entered at posedge+1 with requests driven; the
  // model decides this cycle's grants from the rules, DUT outputs are compared
  // at posedge+2, then the edge is taken and granted requesters move on.
  task automatic step();
    int order [N];
    int wr_i;
    int rd_i [2];
    int nrd;
    int first;
    logic [N-1:0] g;
    #1;
    for (int k = 0; k < N; k++) order[k] = (m_ptr + k) % N;
    wr_i = -1;
    nrd  = 0;
    g    = '0;
    rd_i[0] = 0;
    rd_i[1] = 0;
    for (int k = 0; k < N; k++) begin
      if (wr_i < 0 && bus.iReqValid[order[k]] && bus.iReqWrite[order[k]]) wr_i = order[k];
    end
    for (int k = 0; k < N; k++) begin
      if (nrd < 2 && bus.iReqValid[order[k]] && !bus.iReqWrite[order[k]] &&
          !(wr_i >= 0 && req_addr(order[k]) == req_addr(wr_i))) begin
        rd_i[nrd] = order[k];
        nrd++;
      end
    end
    if (wr_i >= 0) g[wr_i] = 1'b1;
    for (int r = 0; r < nrd; r++) g[rd_i[r]] = 1'b1;

    check("grant", 64'(bus.oReqGrant), 64'(g));
    check("ram_we", 64'(bus.oRamWriteEnable), 64'(wr_i >= 0));
    if (wr_i >= 0) begin
      check("ram_waddr", 64'(bus.oRamWriteAddr), 64'(req_addr(wr_i)));
      check("ram_wdata", 64'(bus.oRamWriteData), 64'(req_data(wr_i)));
    end
    check("ram_raddr0", 64'(bus.oRamReadAddr0), (nrd > 0) ? 64'(req_addr(rd_i[0])) : 64'd0);
    check("ram_raddr1", 64'(bus.oRamReadAddr1), (nrd > 1) ? 64'(req_addr(rd_i[1])) : 64'd0);

    for (int i = 0; i < N; i++) begin
      if (bus.iReqValid[i] && !bus.oReqGrant[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end

    // Reads return the memory as it was before this cycle's write.
    for (int r = 0; r < nrd; r++) begin
      exp_q.push_back({32'(cyc), 8'(rd_i[r]), m_mem[req_addr(rd_i[r])]});
    end
    if (wr_i >= 0) m_mem[req_addr(wr_i)] = req_data(wr_i);

    first = -1;
    for (int k = 0; k < N; k++) begin
      if (first < 0 && g[order[k]]) first = order[k];
    end
    if (first >= 0) m_ptr = (first + 1) % N;
    last_grant = g;
    last_nrd   = nrd;

    @(posedge Clock);
    #1;
    for (int i = 0; i < N; i++) begin
      if (g[i] || !bus.iReqValid[i]) new_op(i, mode);
    end
  endtask

  // Reset pulse entered at posedge+1; in-flight reads are forgotten.
  task automatic reset_pulse(input int cycles);
    Reset_n = 1'b0;
    exp_q.delete();
    m_ptr = 0;
    repeat (cycles) @(posedge Clock);
    #1;
    check("reset_rsp_valid", 64'(bus.oRspValid), 64'd0);
    check("reset_rsp_data_zero", 64'(|bus.oRspData), 64'd0);
    Reset_n = 1'b1;
  endtask

  // ---------------- response monitor ----------------
  initial begin
    logic [EW-1:0] e;
    logic [N-1:0]  exp_mask;
    int            ei;
    forever begin
      @(posedge Clock);
      #3;
      exp_mask = '0;
      while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == cyc - 1) begin
        e  = exp_q.pop_front();
        ei = int'(e[DW +: 8]);
        exp_mask[ei] = 1'b1;
        check("rsp_data", 64'(bus.oRspData[ei*DW +: DW]), 64'(e[DW-1:0]));
      end
      check("rsp_valid", 64'(bus.oRspValid), 64'(exp_mask));
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      ram[a]   <= DW'(a * 37 + 5) ^ DW'($urandom);
    end
    #0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int i = 0; i < N; i++) new_op(i, 1);
    @(posedge Clock);
    #1;
    for (int a = 0; a < DEPTH; a++) m_mem[a] = ram[a];

    // Reset with every requester valid, then four held readers 10..13.
    reset_pulse(3);
    step();
    check("first_grant_req0", 64'(last_grant[0]), 64'd1);
    repeat (7) step();

    // Drain to idle.
    mode = 3;
    for (int t = 0; t < 2 * N; t++) if (|bus.iReqValid) step();
    check("drained", 64'(bus.iReqValid), 64'd0);

    // Write/read collision on address 5: the read waits one cycle.
    set_req(1, 1'b1, 1'b1, AW'(5), DW'(8'hAA));
    set_req(2, 1'b1, 1'b0, AW'(5), '0);
    step();
    check("conflict_write_only", 64'(last_grant), 64'b0010);
    step();
    check("deferred_read", 64'(last_grant), 64'b0100);

    // Two writers with pointer at 3: req3 first, req0 next.
    set_req(0, 1'b1, 1'b1, AW'(30), DW'($urandom));
    set_req(3, 1'b1, 1'b1, AW'(31), DW'($urandom));
    step();
    check("writer_req3_first", 64'(last_grant), 64'b1000);
    step();
    check("writer_req0_next", 64'(last_grant), 64'b0001);

    // Saturated requesters: nobody waits N cycles.
    mode = 2;
    for (int i = 0; i < N; i++) begin
      new_op(i, 2);
      wait_cnt[i] = 0;
    end
    max_wait = 0;
    repeat (40) step();
    check("fairness_within_n", 64'(max_wait < N), 64'd1);

    // Random traffic with one reset the cycle after a read grant.
    mode = 0;
    for (int i = 0; i < N; i++) new_op(i, 0);
    begin
      bit done_reset;
      done_reset = 1'b0;
      for (int it = 0; it < 400; it++) begin
        step();
        if (!done_reset && it >= 150 && last_nrd > 0) begin
          reset_pulse(2);
          done_reset = 1'b1;
        end
      end
      check("mid_reset_done", 64'(done_reset), 64'd1);
    end

    mode = 3;
    repeat (2 * N) step();
    repeat (3) @(posedge Clock);
    #4;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
